// File: rtl/tmss_lock_ctrl.sv
// TMSS lock controller: security latch, cartridge map register and VDP access gating on the 68k bus.
// The lock is built only when TMSS_LOCK_CTRL_EN is defined; otherwise the console runs permanently unlocked.
module tmss_lock_ctrl (
  input  logic        MCLK,
  input  logic        reset,
  input  logic [22:0] VA,
  input  logic [15:0] VD_i,
  input  logic        AS,
  input  logic        UDS,
  input  logic        LDS,
  input  logic        RW,
  input  logic        INTAK,
  output logic [15:0] VD_o,
  output logic        data_out_en,
  output logic        DTACK,
  output logic        vdp_unlock,
  output logic        cart_map,
  output logic        vdp_block
);

`ifdef TMSS_LOCK_CTRL_EN

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_SEC_HI,
    SEL_SEC_LO,
    SEL_MAP
  } sel_t;

  localparam logic [22:0] ADDR_SEC_HI = 23'h50A000;
  localparam logic [22:0] ADDR_SEC_LO = 23'h50A001;
  localparam logic [22:0] ADDR_MAP    = 23'h50A080;
  localparam logic [31:0] UNLOCK_KEY  = 32'h53454741;  // "SEGA"
  localparam logic [1:0]  WAIT_LAST   = 2'd2;

  state_t      state, state_nx;
  sel_t        sel_q, sel_nx, hit_sel;
  logic [1:0]  wait_cnt, wait_cnt_nx;
  logic        rd_q, rd_nx;
  logic        as_d;
  logic        cycle_start;
  logic        commit;
  logic [15:0] sec_hi, sec_lo;
  logic        cart_map_q;
  logic        unlock_q;
  logic        block_q;
  logic [15:0] rd_mux;

  assign cycle_start = !AS && as_d && !INTAK;

  always_comb begin
    hit_sel = SEL_NONE;
    case (VA)
      ADDR_SEC_HI: hit_sel = SEL_SEC_HI;
      ADDR_SEC_LO: hit_sel = SEL_SEC_LO;
      ADDR_MAP:    hit_sel = SEL_MAP;
      default:     hit_sel = SEL_NONE;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    sel_nx      = sel_q;
    rd_nx       = rd_q;
    commit      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cycle_start && (hit_sel != SEL_NONE)) begin
          state_nx    = ST_WAIT;
          wait_cnt_nx = 2'd0;
          sel_nx      = hit_sel;
          rd_nx       = RW;
        end
      end
      ST_WAIT: begin
        // Strobe released early: the CPU gave up, so nothing is written.
        if (AS) begin
          state_nx = ST_IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = ST_ACK;
          commit   = !rd_q;
        end else begin
          wait_cnt_nx = wait_cnt + 2'd1;
        end
      end
      ST_ACK: begin
        if (AS) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 16'h0000;
    case (sel_q)
      SEL_SEC_HI: rd_mux = sec_hi;
      SEL_SEC_LO: rd_mux = sec_lo;
      SEL_MAP:    rd_mux = {15'b0, cart_map_q};
      default:    rd_mux = 16'h0000;
    endcase
  end

  always_comb begin
    DTACK       = (state != ST_ACK);
    data_out_en = (state == ST_ACK) && rd_q;
    VD_o        = data_out_en ? rd_mux : 16'h0000;
  end

  assign vdp_unlock = unlock_q;
  assign cart_map   = cart_map_q;
  assign vdp_block  = block_q;

  // NOTE: state is updated only with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= 2'd0;
      sel_q      <= SEL_NONE;
      rd_q       <= 1'b0;
      as_d       <= 1'b0;
      sec_hi     <= 16'h0000;
      sec_lo     <= 16'h0000;
      cart_map_q <= 1'b0;
      unlock_q   <= 1'b0;
      block_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      sel_q    <= sel_nx;
      rd_q     <= rd_nx;
      as_d     <= AS;
      unlock_q <= ({sec_hi, sec_lo} == UNLOCK_KEY);

      if (commit) begin
        case (sel_q)
          SEL_SEC_HI: begin
            if (!UDS) sec_hi[15:8] <= VD_i[15:8];
            if (!LDS) sec_hi[7:0]  <= VD_i[7:0];
          end
          SEL_SEC_LO: begin
            if (!UDS) sec_lo[15:8] <= VD_i[15:8];
            if (!LDS) sec_lo[7:0]  <= VD_i[7:0];
          end
          SEL_MAP: begin
            if (!LDS) cart_map_q <= VD_i[0];
          end
          default: ;
        endcase
      end

      // Locked VDP accesses are held off until the CPU releases the strobe.
      if (AS) begin
        block_q <= 1'b0;
      end else if (cycle_start && (VA[22:20] == 3'b110) && !unlock_q) begin
        block_q <= 1'b1;
      end
    end
  end

`else

  logic unused_inputs;
  assign unused_inputs = ^{MCLK, reset, VA, VD_i, AS, UDS, LDS, RW, INTAK};

  assign VD_o        = 16'h0000;
  assign data_out_en = 1'b0;
  assign DTACK       = 1'b1;
  assign vdp_unlock  = 1'b1;
  assign cart_map    = 1'b1;
  assign vdp_block   = 1'b0;

`endif

endmodule

// File: tb/tb_tmss_lock_ctrl.sv
// Directed bench for tmss_lock_ctrl: a table of bus cycles plus hand-written corner sequences.
// Covers both builds, selected by TMSS_LOCK_CTRL_EN.
module tb_tmss_lock_ctrl;

  logic        MCLK;
  logic        reset;
  logic [22:0] VA;
  logic [15:0] VD_i;
  logic        AS, UDS, LDS, RW, INTAK;
  logic [15:0] VD_o;
  logic        data_out_en, DTACK, vdp_unlock, cart_map, vdp_block;

  int checks   = 0;
  int failures = 0;

  localparam int NO_ACK = 10;

  tmss_lock_ctrl dut (
    .MCLK        (MCLK),
    .reset       (reset),
    .VA          (VA),
    .VD_i        (VD_i),
    .AS          (AS),
    .UDS         (UDS),
    .LDS         (LDS),
    .RW          (RW),
    .INTAK       (INTAK),
    .VD_o        (VD_o),
    .data_out_en (data_out_en),
    .DTACK       (DTACK),
    .vdp_unlock  (vdp_unlock),
    .cart_map    (cart_map),
    .vdp_block   (vdp_block)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  typedef struct {
    logic [22:0] addr;
    logic        rw;
    logic [15:0] data;
    logic        uds;
    logic        lds;
    int          lat;
    logic [15:0] rdata;
    logic        oe;
    logic        unl_ack;
    logic        unl;
    logic        cart;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [22:0] addr, input logic rw, input logic [15:0] data,
                              input logic uds, input logic lds, input int lat,
                              input logic [15:0] rdata, input logic oe, input logic unl_ack,
                              input logic unl, input logic cart);
    vec_t v;
    v.addr = addr; v.rw = rw; v.data = data; v.uds = uds; v.lds = lds;
    v.lat = lat; v.rdata = rdata; v.oe = oe; v.unl_ack = unl_ack; v.unl = unl; v.cart = cart;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  // Runs one bus cycle; lat counts edges from strobe assertion to DTACK low (NO_ACK if none).
  task automatic bus_cycle(input logic [22:0] addr, input logic rw, input logic [15:0] data,
                           input logic uds, input logic lds, output int lat,
                           output logic [15:0] rdata, output logic oe, output logic unl_ack);
    VA = addr; RW = rw; VD_i = data; UDS = uds; LDS = lds; AS = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (DTACK === 1'b1 && lat < NO_ACK);
    rdata   = VD_o;
    oe      = data_out_en;
    unl_ack = vdp_unlock;
    AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [15:0] rdata;
    logic        oe, unl_ack;

    reset = 1'b1; AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1; INTAK = 1'b0;
    VA = 23'h0; VD_i = 16'h0;
    repeat (3) step();
    reset = 1'b0;
    step();

`ifdef TMSS_LOCK_CTRL_EN
    check("rst_dtack",  DTACK, 1);
    check("rst_oe",     data_out_en, 0);
    check("rst_vd",     VD_o, 0);
    check("rst_unlock", vdp_unlock, 0);
    check("rst_cart",   cart_map, 0);
    check("rst_block",  vdp_block, 0);

    //                  addr        rw    data      uds   lds   lat     rdata     oe    unl@ack unl  cart
    vecs.push_back(mk(23'h50A000, 1'b0, 16'h53AA, 1'b0, 1'b1, 4,      16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(23'h50A000, 1'b1, 16'h0000, 1'b1, 1'b1, 4,      16'h5300, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(23'h50A000, 1'b0, 16'h1245, 1'b1, 1'b0, 4,      16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(23'h50A000, 1'b1, 16'h0000, 1'b1, 1'b1, 4,      16'h5345, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(23'h50A001, 1'b0, 16'h4741, 1'b0, 1'b0, 4,      16'h0000, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(23'h50A001, 1'b1, 16'h0000, 1'b1, 1'b1, 4,      16'h4741, 1'b1, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(23'h50A080, 1'b0, 16'h0001, 1'b1, 1'b0, 4,      16'h0000, 1'b0, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(23'h50A080, 1'b1, 16'h0000, 1'b1, 1'b1, 4,      16'h0001, 1'b1, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(23'h50A080, 1'b0, 16'h0000, 1'b0, 1'b1, 4,      16'h0000, 1'b0, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(23'h50A002, 1'b1, 16'h0000, 1'b1, 1'b1, NO_ACK, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(23'h50A001, 1'b0, 16'h0000, 1'b0, 1'b0, 4,      16'h0000, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(23'h50A080, 1'b1, 16'h0000, 1'b1, 1'b1, 4,      16'h0001, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(23'h50A080, 1'b0, 16'h0000, 1'b1, 1'b0, 4,      16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(23'h50A001, 1'b1, 16'h0000, 1'b1, 1'b1, 4,      16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
`else
    check("rst_dtack",  DTACK, 1);
    check("rst_oe",     data_out_en, 0);
    check("rst_vd",     VD_o, 0);
    check("rst_unlock", vdp_unlock, 1);
    check("rst_cart",   cart_map, 1);
    check("rst_block",  vdp_block, 0);

    vecs.push_back(mk(23'h50A000, 1'b0, 16'h5345, 1'b0, 1'b0, NO_ACK, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(23'h50A001, 1'b0, 16'h4741, 1'b0, 1'b0, NO_ACK, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(23'h50A000, 1'b1, 16'h0000, 1'b1, 1'b1, NO_ACK, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(23'h50A080, 1'b0, 16'h0000, 1'b1, 1'b0, NO_ACK, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      bus_cycle(vecs[i].addr, vecs[i].rw, vecs[i].data, vecs[i].uds, vecs[i].lds,
                lat, rdata, oe, unl_ack);
      check($sformatf("v%0d_lat", i),     lat,        vecs[i].lat);
      check($sformatf("v%0d_rdata", i),   rdata,      vecs[i].rdata);
      check($sformatf("v%0d_oe", i),      oe,         vecs[i].oe);
      check($sformatf("v%0d_unl_ack", i), unl_ack,    vecs[i].unl_ack);
      check($sformatf("v%0d_unlock", i),  vdp_unlock, vecs[i].unl);
      check($sformatf("v%0d_cart", i),    cart_map,   vecs[i].cart);
    end

`ifdef TMSS_LOCK_CTRL_EN
    // Locked VDP access: block from cycle start until the strobe is released.
    VA = 23'h600000; RW = 1'b1; AS = 1'b0;
    step();
    check("blk_start", vdp_block, 1);
    check("blk_dtack", DTACK, 1);
    repeat (3) step();
    check("blk_hold", vdp_block, 1);
    AS = 1'b1;
    step();
    check("blk_release", vdp_block, 0);

    // Interrupt acknowledge never starts a register cycle.
    VA = 23'h50A000; RW = 1'b1; INTAK = 1'b1; AS = 1'b0;
    repeat (6) step();
    check("intak_dtack", DTACK, 1);
    AS = 1'b1; INTAK = 1'b0;
    step();

    // Unlocked: VDP access is not blocked.
    bus_cycle(23'h50A000, 1'b0, 16'h5345, 1'b0, 1'b0, lat, rdata, oe, unl_ack);
    bus_cycle(23'h50A001, 1'b0, 16'h4741, 1'b0, 1'b0, lat, rdata, oe, unl_ack);
    check("relock_unlock", vdp_unlock, 1);
    VA = 23'h600000; AS = 1'b0;
    step();
    check("unl_blk", vdp_block, 0);
    AS = 1'b1;
    step();

    // Abandoned write in WAIT: no commit, no acknowledge.
    VA = 23'h50A000; RW = 1'b0; VD_i = 16'h0000; UDS = 1'b0; LDS = 1'b0; AS = 1'b0;
    step();
    step();
    AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("abandon_dtack%0d", i), DTACK, 1);
    end
    check("abandon_unlock", vdp_unlock, 1);
    bus_cycle(23'h50A000, 1'b1, 16'h0000, 1'b1, 1'b1, lat, rdata, oe, unl_ack);
    check("abandon_sec_hi", rdata, 16'h5345);

    // Reset during the acknowledge of a MAP write, with the strobe held low.
    VA = 23'h50A080; RW = 1'b0; VD_i = 16'h0001; UDS = 1'b1; LDS = 1'b0; AS = 1'b0;
    repeat (4) step();
    check("rmap_ack_dtack", DTACK, 0);
    check("rmap_ack_cart", cart_map, 1);
    reset = 1'b1;
    step();
    check("rmap_rst_dtack", DTACK, 1);
    check("rmap_rst_cart", cart_map, 0);
    check("rmap_rst_unlock", vdp_unlock, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rmap_hold_dtack%0d", i), DTACK, 1);
    end
    AS = 1'b1; LDS = 1'b1; RW = 1'b1;
    step();
    bus_cycle(23'h50A080, 1'b1, 16'h0000, 1'b1, 1'b1, lat, rdata, oe, unl_ack);
    check("rmap_new_lat", lat, 4);
    check("rmap_new_rdata", rdata, 16'h0000);
    check("rmap_new_oe", oe, 1);
`else
    VA = 23'h600000; RW = 1'b1; AS = 1'b0;
    step();
    check("dis_blk", vdp_block, 0);
    check("dis_blk_dtack", DTACK, 1);
    AS = 1'b1;
    step();
    check("dis_unlock", vdp_unlock, 1);
    check("dis_cart", cart_map, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmss_lock_ctrl.md
TMSS_LOCK_CTRL -- requirements
Module: tmss_lock_ctrl

Interface
REQ-001 SHALL have one clock, MCLK (input, 1): all state changes on its rising edge.
REQ-002 SHALL have reset (input, 1): synchronous, active-high.
REQ-003 SHALL have VA (input, 23): 68k word address A23..A1.
REQ-004 SHALL have VD_i (input, 16): 68k write data.
REQ-005 SHALL have AS, UDS, LDS (inputs, 1 each): active-low strobes.
REQ-006 SHALL have RW (input, 1): 1 = read, 0 = write.
REQ-007 SHALL have INTAK (input, 1): 1 = interrupt-acknowledge cycle.
REQ-008 SHALL have VD_o (output, 16): read data.
REQ-009 SHALL have data_out_en (output, 1): 1 = drive VD_o onto the bus.
REQ-010 SHALL have DTACK (output, 1): active-low acknowledge.
REQ-011 SHALL have vdp_unlock (output, 1): 1 = VDP access permitted.
REQ-012 SHALL have cart_map (output, 1): 0 = boot ROM at 0x000000, 1 = cartridge.
REQ-013 SHALL have vdp_block (output, 1): 1 = locked VDP access in progress; suppresses external DTACK.

Function
REQ-014 SHALL register AS as as_d and detect cycle start when AS=0 and as_d=1, with INTAK=0.
REQ-015 SHALL decode three registers by VA:
- SEC_HI: 0x50A000 (byte 0xA14000)
- SEC_LO: 0x50A001 (byte 0xA14002)
- MAP: 0x50A080 (byte 0xA14100)
REQ-016 SHALL implement FSM IDLE/WAIT/ACK:
- IDLE->WAIT on cycle start with a register hit.
- WAIT lasts exactly 3 MCLK cycles, then ->ACK.
- ACK drives DTACK=0 until AS is sampled 1, then ->IDLE.
REQ-017 SHALL leave non-hit cycles in IDLE with DTACK=1.
REQ-018 SHALL commit writes on the edge entering ACK: SEC_HI/SEC_LO upper byte if UDS=0, lower byte if LDS=0; MAP bit0 from VD_i[0] if LDS=0.
REQ-019 SHALL, for reads, hold VD_o and data_out_en=1 throughout ACK:
- SEC_HI/SEC_LO read return the latch.
- MAP read returns {15'b0, cart_map}.
REQ-020 SHALL set vdp_unlock one cycle after {SEC_HI,SEC_LO}==0x53454741 and clear it one cycle after any write makes them unequal.
REQ-021 SHALL assert vdp_block from cycle start to AS negation when VA[22:20]==3'b110 and vdp_unlock=0.
REQ-022 SHALL ignore a second cycle start while in WAIT or ACK; a new cycle begins only from IDLE.
REQ-023 SHALL abandon a cycle if AS negates during WAIT: ->IDLE, no write commit, DTACK stays 1.

Reset
REQ-024 SHALL, on reset:
- Set FSM=IDLE, SEC_HI=SEC_LO=0, cart_map=0, vdp_unlock=0, vdp_block=0.
- Set DTACK=1, data_out_en=0, VD_o=0.
- Set as_d=0, so no cycle start is detected until AS has been sampled 1.
REQ-025 SHALL discard a bus cycle in progress at reset, with no partial commit.

Configuration
REQ-026 SHALL use macro TMSS_LOCK_CTRL_EN:
- Defined: behaviour per REQ-014..REQ-025.
- Undefined: vdp_unlock=1, cart_map=1, vdp_block=0, DTACK=1, data_out_en=0, VD_o=0 permanently; no registers decoded.

Verification
REQ-027 Write 0x5345 @0x50A000 then 0x4741 @0x50A001 (UDS=LDS=0) -> DTACK=0 three cycles after WAIT entry for each write; vdp_unlock=1 one cycle after the second commit.
REQ-028 Unlocked, then write 0x0000 @0x50A001 -> vdp_unlock=0 one cycle after commit; read @0x600000 -> vdp_block=1 until AS=1.
REQ-029 Write 0x0001 @0x50A080 with LDS=0, UDS=1 -> cart_map=1; read back -> VD_o=0x0001, data_out_en=1 during ACK.
REQ-030 Byte write 0x53xx with UDS=0, LDS=1 @0x50A000 -> SEC_HI=0x5300, lower byte unchanged.
REQ-031 Assert reset during ACK of a MAP write -> DTACK=1, cart_map=0 next cycle; AS held low -> no new cycle until AS toggles high then low.
REQ-032 Build without TMSS_LOCK_CTRL_EN; write 'SEGA' -> DTACK stays 1, vdp_unlock=1, cart_map=1 throughout.
